bus_arb8_rr: RTL and testbench
==============================

# bus_arb8_rr

Round-robin arbiter and grant sequencer for an 8-way shared resource, such as a shared memory/peripheral port. It samples up to eight request lines and grants exactly one owner at a time. The grant is held until the owner releases or a hold timeout expires, with one dead cycle inserted between owners. It drives both a 3-bit owner index and the matching one-hot grant vector, which is the index decoded and gated by grant-valid.

## Interface
- TIMEOUT_CYCLES, 16: maximum consecutive cycles one owner may hold the grant. 0 disables the timeout. Legal range 0..255.
- clk_i  input  1  clock; all state updates on the rising edge
- rst_i  input  1  reset; synchronous and active-high
- en_i  input  1  arbitration enable; when low, no new grant is issued and a current grant runs to completion
- req_i  input  8  request lines; bit k = requester k; level-sensitive
- done_i  input  1  single-cycle pulse from the resource: the current transfer is complete, release the grant
- gnt_o  output  8  one-hot grant; all zeros when no owner
- gnt_idx_o  output  3  index of the current owner; 0 when gnt_valid_o=0
- gnt_valid_o  output  1  high while an owner holds the resource
- timeout_o  output  1  one-cycle pulse marking a forced release

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner holds the grant.
  - GAP: single dead cycle after a release.
- Arbitration occurs only in IDLE and GAP, and only when en_i=1 and req_i != 0.
  - The winner is the first set bit of req_i, searching from (last_idx+1) mod 8 upward with wrap 7->0.
  - The winner is registered: gnt_idx_o <= winner, gnt_valid_o <= 1, state <= BUSY, last_idx <= winner.
- IDLE → BUSY on a win; otherwise stay in IDLE.
- GAP → BUSY on a win; otherwise → IDLE.
- BUSY release conditions (any one):
  - req_i[owner]=0 (owner dropped its request)
  - done_i=1
  - timeout: hold counter == TIMEOUT_CYCLES-1, with TIMEOUT_CYCLES != 0
- BUSY → GAP on release: clear gnt_valid_o and gnt_idx_o.
- Hold counter:
  - Cleared on entry to BUSY; increments each BUSY cycle.
  - Width is ceil(log2(TIMEOUT_CYCLES+1)), minimum 1 bit.
  - Saturates; it never wraps.
- timeout_o is high for the single GAP cycle after a timeout release. It is not asserted if the owner dropped its request or done_i=1 in the same cycle; a natural release takes precedence.
- gnt_o = gnt_valid_o ? (8'b1 << gnt_idx_o) : 8'b0. It must never have more than one bit set.
- Requests from non-owners during BUSY are ignored; they are reconsidered in GAP.
- en_i is ignored in BUSY.
- A timed-out owner becomes lowest priority because last_idx already points at it.

## Timing
- Reset values: gnt_o=0, gnt_idx_o=0, gnt_valid_o=0, timeout_o=0, state=IDLE, last_idx=7 (requester 0 has first priority), hold counter=0.
- Reset is synchronous. If rst_i is sampled high mid-BUSY, all outputs above are zero in the following cycle and the grant is lost without timeout_o.
- Grant latency from IDLE: req_i sampled at edge N gives gnt_o valid from cycle N+1.
- Handover: release condition sampled in cycle M (grant high during M):
  - M+1 is the GAP cycle, with gnt_o=0.
  - The earliest next grant is visible in M+2.
- Maximum hold: TIMEOUT_CYCLES cycles of gnt_valid_o=1 per grant.
- Worst-case wait for a continuously requesting line: 7 × (TIMEOUT_CYCLES+1) cycles after its first GAP/IDLE sample.
- done_i asserted in IDLE or GAP is ignored.

## Test plan
- Reset/idle:
  - Stimulus: rst_i=1 for 2 cycles, then req_i=0.
  - Required: every output is 0 on each cycle; state stays in IDLE.
- Single requester:
  - Stimulus: req_i=8'h10 from cycle 5; drop it at cycle 9.
  - Required: gnt_o=8'h10 and gnt_idx_o=4 in cycles 6..9; gnt_o=0 in cycle 10 (GAP); idle from cycle 11.
- Round-robin fairness:
  - Stimulus: req_i=8'hFF held; each owner pulses done_i on its 2nd BUSY cycle.
  - Required: grant order 0,1,2,…,7,0 with wrap, one GAP cycle between owners, never two bits set.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4; req_i=8'h03 held; no done_i.
  - Required: requester 0 is granted for exactly 4 cycles; GAP follows with timeout_o=1; requester 1 is granted next for 4 cycles; then requester 0 again.
- Precedence and enable:
  - Stimulus: done_i on the same cycle as the timeout.
    - Required: timeout_o stays 0.
  - Stimulus: en_i=0 during GAP with req_i=8'h80.
    - Required: no grant.
  - Stimulus: en_i returns to 1.
    - Required: gnt_o=8'h80 on the next cycle.
- Reset mid-grant:
  - Stimulus: rst_i=1 during BUSY with owner 3.
  - Required: next cycle gnt_o=0, timeout_o=0.
  - Stimulus: after reset, req_i=8'h09.
    - Required: requester 0 wins, since the pointer is reset to 7.

Source files
------------

// File: rtl/bus_arb8_rr_if.sv
// Request/grant bundle shared by the 8-way round-robin arbiter and its requesters.
// The arbiter uses the slave modport; whoever drives requests uses the master modport.
interface bus_arb8_rr_if;
  logic       en_i;
  logic [7:0] req_i;
  logic       done_i;
  logic [7:0] gnt_o;
  logic [2:0] gnt_idx_o;
  logic       gnt_valid_o;
  logic       timeout_o;

  modport master (
    output en_i,
    output req_i,
    output done_i,
    input  gnt_o,
    input  gnt_idx_o,
    input  gnt_valid_o,
    input  timeout_o
  );

  modport slave (
    input  en_i,
    input  req_i,
    input  done_i,
    output gnt_o,
    output gnt_idx_o,
    output gnt_valid_o,
    output timeout_o
  );
endinterface

// File: rtl/bus_arb8_rr.sv
// 8-way round-robin arbiter: one owner at a time, held until release or hold timeout,
// with a single dead cycle between owners. All outputs are registered.
module bus_arb8_rr #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic          clk_i,
  input logic          rst_i,
  bus_arb8_rr_if.slave bus
);

  localparam int unsigned    HOLD_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = {HOLD_W{1'b1}};
  localparam logic           TO_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e            state_q;
  logic [2:0]        last_q;
  logic [2:0]        idx_q;
  logic              valid_q;
  logic [7:0]        gnt_q;
  logic              timeout_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;

  logic [3:0] win_s;
  logic       arb_ok_s;
  logic       natural_rel_s;
  logic       to_hit_s;
  logic       release_s;

  // Returns {found, index} of the first set request after 'last', wrapping 7 -> 0.
  function automatic logic [3:0] rr_pick(input logic [7:0] req, input logic [2:0] last);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!res[3] && req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // Winner selection, release detection and saturating hold-count next value.
  always_comb begin
    win_s         = rr_pick(bus.req_i, last_q);
    arb_ok_s      = bus.en_i && win_s[3];
    natural_rel_s = !bus.req_i[idx_q] || bus.done_i;
    to_hit_s      = TO_EN && (hold_q == HOLD_LAST);
    release_s     = natural_rel_s || to_hit_s;
    if (hold_q == HOLD_MAX) begin
      hold_d = hold_q;
    end else begin
      hold_d = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
    end
  end

  // Grant sequencer FSM with registered grant, index, valid and timeout outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      last_q    <= 3'd7;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      gnt_q     <= 8'd0;
      timeout_q <= 1'b0;
      hold_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_GAP: begin
          timeout_q <= 1'b0;
          if (arb_ok_s) begin
            state_q <= ST_BUSY;
            last_q  <= win_s[2:0];
            idx_q   <= win_s[2:0];
            valid_q <= 1'b1;
            gnt_q   <= 8'd1 << win_s[2:0];
            hold_q  <= '0;
          end else begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            valid_q <= 1'b0;
            gnt_q   <= 8'd0;
          end
        end
        ST_BUSY: begin
          if (release_s) begin
            // A natural release in the same cycle suppresses the timeout flag.
            state_q   <= ST_GAP;
            idx_q     <= 3'd0;
            valid_q   <= 1'b0;
            gnt_q     <= 8'd0;
            timeout_q <= to_hit_s && !natural_rel_s;
          end else begin
            hold_q    <= hold_d;
            timeout_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          idx_q     <= 3'd0;
          valid_q   <= 1'b0;
          gnt_q     <= 8'd0;
          timeout_q <= 1'b0;
          hold_q    <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_o       = gnt_q;
  assign bus.gnt_idx_o   = idx_q;
  assign bus.gnt_valid_o = valid_q;
  assign bus.timeout_o   = timeout_q;

endmodule

// File: tb/tb_bus_arb8_rr.sv
// Self-checking bench for bus_arb8_rr: directed scenarios plus randomized traffic,
// every cycle compared against an owner/hold-count reference model.
module tb_bus_arb8_rr;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_arb8_rr_if bif();

  bus_arb8_rr #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: current owner (-1 = none), last winner, cycles held so far.
  int m_owner = -1;
  int m_last  = 7;
  int m_held  = 0;
  bit m_to    = 1'b0;

  function automatic int rr_ref(input logic [7:0] r, input int last);
    for (int k = 1; k <= 8; k++) begin
      int w;
      w = (last + k) % 8;
      if (r[w]) return w;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [7:0] r, input logic d, input logic e, input logic rs);
    if (rs) begin
      m_owner = -1; m_last = 7; m_held = 0; m_to = 1'b0;
    end else if (m_owner >= 0) begin
      bit nat, tmo;
      nat = !r[m_owner] || d;
      tmo = (T != 0) && (m_held == T);
      if (nat || tmo) begin
        m_owner = -1;
        m_to    = tmo && !nat;
      end else begin
        m_held++;
        m_to = 1'b0;
      end
    end else begin
      int w;
      m_to = 1'b0;
      w = rr_ref(r, m_last);
      if (e && w >= 0) begin
        m_owner = w; m_last = w; m_held = 1;
      end
    end
  endtask

  task automatic step(input logic [7:0] r, input logic d, input logic e, input logic rs);
    logic [7:0] eg;
    logic [7:0] ei;
    @(negedge clk);
    bif.req_i = r; bif.done_i = d; bif.en_i = e; rst = rs;
    @(posedge clk);
    model(r, d, e, rs);
    #1;
    eg = (m_owner >= 0) ? (8'd1 << m_owner) : 8'd0;
    ei = (m_owner >= 0) ? 8'(m_owner) : 8'd0;
    chk("gnt",       bif.gnt_o, eg);
    chk("gnt_idx",   {5'd0, bif.gnt_idx_o}, ei);
    chk("gnt_valid", {7'd0, bif.gnt_valid_o}, {7'd0, (m_owner >= 0)});
    chk("timeout",   {7'd0, bif.timeout_o}, {7'd0, m_to});
    chk("onehot",    {7'd0, ($countones(bif.gnt_o) <= 1)}, 8'd1);
  endtask

  initial begin
    logic [2:0] order[$];
    int         runs[$];
    logic       prev;
    logic       d;
    logic [7:0] r;
    int         run;
    int         tos;

    bif.req_i = 8'd0; bif.done_i = 1'b0; bif.en_i = 1'b1;

    // Reset and idle
    step(8'd0, 1'b0, 1'b1, 1'b1);
    step(8'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(8'd0, 1'b0, 1'b1, 1'b0);
    chk("idle_gnt", bif.gnt_o, 8'd0);

    // Single requester 4 held for four cycles then dropped
    for (int i = 0; i < 4; i++) begin
      step(8'h10, 1'b0, 1'b1, 1'b0);
      chk("single_gnt", bif.gnt_o, 8'h10);
      chk("single_idx", {5'd0, bif.gnt_idx_o}, 8'd4);
    end
    step(8'h00, 1'b0, 1'b1, 1'b0);
    chk("single_gap", bif.gnt_o, 8'd0);
    step(8'h00, 1'b0, 1'b1, 1'b0);
    chk("single_idle", {7'd0, bif.gnt_valid_o}, 8'd0);

    // Round-robin fairness: all request, each owner signals done on its 2nd cycle
    step(8'd0, 1'b0, 1'b1, 1'b1);
    prev = 1'b0;
    order.delete();
    for (int i = 0; i < 27; i++) begin
      d = (m_owner >= 0) && (m_held == 2);
      step(8'hFF, d, 1'b1, 1'b0);
      if (bif.gnt_valid_o && !prev) order.push_back(bif.gnt_idx_o);
      prev = bif.gnt_valid_o;
    end
    chk("rr_count", 8'(order.size()), 8'd9);
    for (int i = 0; i < 9 && i < order.size(); i++) chk("rr_order", {5'd0, order[i]}, 8'(i % 8));

    // Timeout: two persistent requesters, no done
    step(8'd0, 1'b0, 1'b1, 1'b1);
    prev = 1'b0; run = 0; tos = 0;
    order.delete(); runs.delete();
    for (int i = 0; i < 16; i++) begin
      step(8'h03, 1'b0, 1'b1, 1'b0);
      if (bif.gnt_valid_o) run++;
      else if (prev) begin runs.push_back(run); run = 0; end
      if (bif.gnt_valid_o && !prev) order.push_back(bif.gnt_idx_o);
      tos += int'(bif.timeout_o);
      prev = bif.gnt_valid_o;
    end
    chk("to_pulses", 8'(tos), 8'd3);
    chk("to_runs", 8'(runs.size()), 8'd3);
    for (int i = 0; i < 3 && i < runs.size(); i++) chk("to_len", 8'(runs[i]), 8'(T));
    chk("to_grants", 8'(order.size()), 8'd4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("to_order", {5'd0, order[i]}, 8'(i % 2));

    // done on the very cycle the timeout would fire: natural release wins
    step(8'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < T; i++) step(8'h01, 1'b0, 1'b1, 1'b0);
    step(8'h01, 1'b1, 1'b1, 1'b0);
    chk("prec_valid", {7'd0, bif.gnt_valid_o}, 8'd0);
    chk("prec_timeout", {7'd0, bif.timeout_o}, 8'd0);

    // Enable low through GAP and IDLE blocks the grant; re-enabling grants next cycle
    step(8'h80, 1'b0, 1'b0, 1'b0);
    chk("en_gap", bif.gnt_o, 8'd0);
    step(8'h80, 1'b0, 1'b0, 1'b0);
    chk("en_idle", bif.gnt_o, 8'd0);
    step(8'h80, 1'b0, 1'b1, 1'b0);
    chk("en_grant", bif.gnt_o, 8'h80);

    // Reset during a grant to requester 3, then pointer restart check
    step(8'h08, 1'b0, 1'b1, 1'b0);
    step(8'h08, 1'b0, 1'b1, 1'b0);
    chk("mid_owner", {5'd0, bif.gnt_idx_o}, 8'd3);
    step(8'h08, 1'b0, 1'b1, 1'b1);
    chk("mid_rst_gnt", bif.gnt_o, 8'd0);
    chk("mid_rst_to", {7'd0, bif.timeout_o}, 8'd0);
    step(8'h09, 1'b0, 1'b1, 1'b0);
    chk("mid_restart", bif.gnt_o, 8'h01);

    // Randomized traffic with sticky requests so timeouts occur
    r = 8'd0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0:       r = 8'($urandom);
          1:       r = 8'd1 << $urandom_range(0, 7);
          default: r = 8'hFF;
        endcase
      end
      step(r, ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 149) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
